// File: rtl/piso_pkg.sv
// Shared constants for the parallel-in serial-out register and its bench.
package piso_pkg;

    localparam int unsigned PISO_DEFAULT_WIDTH = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage : piso_pkg

// File: rtl/piso_register_if.sv
// Load handshake and serial output bundle of piso_register.
interface piso_register_if
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) ();

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             done;
    logic [CNT_W-1:0] bits_remaining;

    // Producer/consumer side of the block
    modport master (
        output parallel_in,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  done,
        input  bits_remaining
    );

    // The serializer itself
    modport slave (
        input  parallel_in,
        input  load_valid,
        output load_ready,
        output serial_out,
        output serial_valid,
        output done,
        output bits_remaining
    );

endinterface : piso_register_if

// File: rtl/piso_register.sv
// Serializes a WIDTH-bit word one bit per clock behind a valid/ready load.
// Optional PISO_BACK_TO_BACK_EN: accept the next word in the last-bit cycle.
module piso_register
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    piso_register_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_serial_out;
    logic             r_done;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_serial_out_nxt;
    logic             w_done_nxt;
    logic             w_last;
    logic             w_load_ready;
    logic             w_accept;

    assign w_last = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(1));

`ifdef PISO_BACK_TO_BACK_EN
    assign w_load_ready = !reset && ((r_state == ST_IDLE) || w_last);
`else
    assign w_load_ready = !reset && (r_state == ST_IDLE);
`endif

    assign w_accept = bus.load_valid && w_load_ready;

    // r_shift holds only the bits not yet driven; the current bit lives in r_serial_out
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_cnt_nxt        = r_cnt;
        w_serial_out_nxt = 1'b0;
        w_done_nxt       = 1'b0;

        if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_cnt_nxt   = CNT_W'(WIDTH);
            if (LSB_FIRST) begin
                w_serial_out_nxt = bus.parallel_in[0];
                w_shift_nxt      = bus.parallel_in >> 1;
            end else begin
                w_serial_out_nxt = bus.parallel_in[WIDTH-1];
                w_shift_nxt      = bus.parallel_in << 1;
            end
        end else if (r_state == ST_SHIFT) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_shift_nxt = '0;
            end else begin
                w_cnt_nxt  = r_cnt - CNT_W'(1);
                w_done_nxt = (r_cnt == CNT_W'(2));
                if (LSB_FIRST) begin
                    w_serial_out_nxt = r_shift[0];
                    w_shift_nxt      = r_shift >> 1;
                end else begin
                    w_serial_out_nxt = r_shift[WIDTH-1];
                    w_shift_nxt      = r_shift << 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_serial_out <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_serial_out <= w_serial_out_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.load_ready     = w_load_ready;
    assign bus.serial_out     = r_serial_out;
    assign bus.serial_valid   = (r_state == ST_SHIFT);
    assign bus.done           = r_done;
    assign bus.bits_remaining = r_cnt;

endmodule : piso_register

// File: doc/piso_register.md
# piso_register

Parallel-in, serial-out shift register that serializes a WIDTH-bit word one bit per clock behind a valid/ready load handshake. It is the transmit-side counterpart of sipo_register. With the default LSB-first ordering, a sipo_register of the same WIDTH clocked on the same clk reconstructs the original word after WIDTH shifts. It sits between a parallel producer and a single-wire serial link.

## Interface
- WIDTH, 8, word length in bits; legal range WIDTH >= 2.
- LSB_FIRST, 1, shift order: 1 means bit 0 first, 0 means bit WIDTH-1 first.
- CNT_W, $clog2(WIDTH+1), width of bits_remaining; derived, never overridden.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- parallel_in  input  WIDTH  word to serialize; sampled only on acceptance.
- load_valid  input  1  producer has a word on parallel_in.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  current serial bit; registered.
- serial_valid  output  1  serial_out carries a data bit this cycle; registered.
- done  output  1  one-cycle pulse coincident with the last bit of a word.
- bits_remaining  output  CNT_W  bits still to be driven, including the current one; 0 when idle.

## Operation
- Two states: IDLE and SHIFT. Reset value is IDLE.
- Outputs during reset and immediately after it: serial_out=0, serial_valid=0, done=0, bits_remaining=0. load_ready is forced 0 while reset is high and is 1 in IDLE otherwise.
- IDLE: load_ready=1. Acceptance is load_valid && load_ready at a rising edge. On acceptance, capture parallel_in into the shift register, load the counter with WIDTH, and move to SHIFT.
- SHIFT: each cycle drives one bit, shifts the register, and decrements the counter.
  - LSB_FIRST=1 gives bit order 0..WIDTH-1. LSB_FIRST=0 gives WIDTH-1..0.
  - Changes on parallel_in after acceptance have no effect.
- Last bit (bits_remaining==1): done=1. The next state is IDLE, or SHIFT if a back-to-back load is accepted (see Configuration).
- When serial_valid=0, serial_out is held at 0.
- load_valid while busy: ignored; the producer must hold the word until load_ready.
- Reset mid-word: the word is aborted. No done pulse. All outputs return to reset values at the next edge.

## Timing
- A word accepted at edge N has bit i present in the cycle after edge N+i, for i = 0..WIDTH-1.
- serial_valid is high for exactly WIDTH consecutive cycles per word.
- done is high only in the cycle carrying bit WIDTH-1.
- Latency from acceptance to the first bit is 1 cycle. Throughput is WIDTH cycles per word plus a gap (see Configuration).
- bits_remaining reads WIDTH in the first bit cycle and 1 in the last.

## Configuration
- PISO_BACK_TO_BACK_EN defined:
  - load_ready is also 1 in the last-bit cycle of SHIFT.
  - A word accepted there starts its bit 0 in the very next cycle, so serial_valid has no gap. Sustained throughput is one word per WIDTH cycles.
  - done and the load happen in the same cycle.
- PISO_BACK_TO_BACK_EN undefined:
  - load_ready=1 only in IDLE, so at least one idle cycle (serial_valid=0) separates words.
  - Sustained throughput is one word per WIDTH+1 cycles.

## Structure
- Shared package piso_pkg holds:
  - the state encoding constants (ST_IDLE, ST_SHIFT, 1-bit);
  - a default-width constant PISO_DEFAULT_WIDTH=8 used by both this block and its bench.
- No sub-module: the shift register, down-counter, and two-state FSM form one flat module.

## Test plan
- Reset: hold reset 2 cycles with load_valid=1 -> no acceptance, all outputs 0; load_ready=1 in the first cycle after reset deasserts.
- Single word: load 8'b10110101 with LSB_FIRST=1 -> serial_out sequence 1,0,1,0,1,1,0,1, serial_valid high 8 cycles, done only on the 8th, bits_remaining 8 down to 1.
- Loopback: drive serial_out into sipo_register (WIDTH=8) for 8 cycles -> parallel_out_full==8'b10110101.
- MSB-first: LSB_FIRST=0, load 8'hA5 -> sequence 1,0,1,0,0,1,0,1.
- Back-to-back: load_valid held with 8'h0F then 8'hF0 -> gap-free 16 valid bits when PISO_BACK_TO_BACK_EN is defined; exactly one idle cycle between words when it is not.
- Abort: assert reset after bit 3 of 8'hFF -> outputs 0 at the next edge, no done. The next load of 8'h01 serializes cleanly as 1,0,0,0,0,0,0,0.
